// File: rtl/ser2par_rx_if.sv
// Handshake and data bundle between a serial bit source and ser2par_rx.
// The master drives the strobe, data, frame start and ready; the slave returns the word and status.
interface ser2par_rx_if #(
   parameter int unsigned N = 4
);
   logic         en;
   logic         SI;
   logic         start;
   logic         ready;
   logic [N-1:0] q;
   logic         valid;
   logic         busy;
   logic         ovf;

   modport master (
      output en, SI, start, ready,
      input  q, valid, busy, ovf
   );

   modport slave (
      input  en, SI, start, ready,
      output q, valid, busy, ovf
   );
endinterface

// File: rtl/ser2par_rx.sv
// Serial-to-parallel receiver: assembles N LSB-first strobed bits into a held output word,
// with a valid/ready handshake and a sticky overrun flag.
module ser2par_rx #(
   parameter int unsigned N = 4
) (
   input logic         clk,
   input logic         rst,
   ser2par_rx_if.slave bus
);
   localparam int unsigned CW = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [0:0] {StIdle, StShift} state_e;

   state_e        state_q;
   logic [CW-1:0] cnt_q;
   logic [N-1:0]  sr_q;
   logic [N-1:0]  q_q;
   logic          valid_q;
   logic          ovf_q;
   logic [N-1:0]  word;

   assign word = {bus.SI, sr_q[N-1:1]};

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         sr_q    <= '0;
         q_q     <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         if (valid_q && bus.ready) begin
            valid_q <= 1'b0;
         end
         case (state_q)
            StIdle: begin
               if (bus.start) begin
                  state_q <= StShift;
                  cnt_q   <= '0;
                  sr_q    <= '0;
               end
            end
            StShift: begin
               if (bus.en) begin
                  sr_q <= word;
                  if (cnt_q == LAST) begin
                     state_q <= StIdle;
                     cnt_q   <= '0;
                     // A word that finds the output occupied and not being drained is dropped.
                     if (!valid_q || bus.ready) begin
                        q_q     <= word;
                        valid_q <= 1'b1;
                     end else begin
                        ovf_q <= 1'b1;
                     end
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.q     = q_q;
   assign bus.valid = valid_q;
   assign bus.ovf   = ovf_q;
   assign bus.busy  = (state_q == StShift);
endmodule

// File: tb/tb_ser2par_rx.sv
// Self-checking bench for ser2par_rx (N=4): expected words are queued as frames are sent
// and popped when the receiver presents them.
module tb_ser2par_rx;
   localparam int unsigned N = 4;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_pass;
   logic [N-1:0] exp_q[$];

   ser2par_rx_if #(.N(N)) bus ();

   ser2par_rx #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sb_compare(input string tag);
      check({tag, "_pending"}, 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
         check({tag, "_q"}, 32'(bus.q), 32'(exp_q.pop_front()));
      end
   endtask

   // gap_at: bit index before which en is held low gap_len cycles (-1 for none).
   task automatic send_frame(input logic [N-1:0] w, input int gap_at, input int gap_len,
                             input bit start_during, input bit ready_last, input bit push);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("busy_frame", 32'(bus.busy), 32'd1);
      for (int i = 0; i < int'(N); i++) begin
         if (i == gap_at) begin
            bus.en = 1'b0;
            repeat (gap_len) tick();
         end
         if (i == int'(N) - 1 && gap_at >= 0) begin
            check("lat_pre", 32'(bus.valid), 32'd0);
         end
         if (i == int'(N) - 1 && ready_last) bus.ready = 1'b1;
         bus.en    = 1'b1;
         bus.SI    = w[i];
         bus.start = start_during && (i == 1 || i == 2);
         tick();
         bus.en    = 1'b0;
         bus.start = 1'b0;
         if (ready_last) bus.ready = 1'b0;
      end
      if (push) exp_q.push_back(w);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      rst       = 1'b0;
      bus.en    = 1'b0;
      bus.SI    = 1'b0;
      bus.start = 1'b0;
      bus.ready = 1'b0;

      // Reset state, with start/en/ready asserted to show reset wins.
      bus.start = 1'b1;
      bus.en    = 1'b1;
      bus.ready = 1'b1;
      do_reset();
      bus.start = 1'b0;
      bus.en    = 1'b0;
      bus.ready = 1'b0;
      check("rst_q", 32'(bus.q), 32'd0);
      check("rst_valid", 32'(bus.valid), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_ovf", 32'(bus.ovf), 32'd0);

      // Basic frame.
      send_frame(4'b1101, -1, 0, 1'b0, 1'b0, 1'b1);
      sb_compare("basic");
      check("basic_valid", 32'(bus.valid), 32'd1);
      check("basic_busy", 32'(bus.busy), 32'd0);
      check("basic_ovf", 32'(bus.ovf), 32'd0);

      // Handshake drains valid; q holds. Ready with valid=0 is harmless.
      bus.ready = 1'b1;
      tick();
      check("hs_valid", 32'(bus.valid), 32'd0);
      check("hs_q", 32'(bus.q), 32'hd);
      tick();
      bus.ready = 1'b0;
      check("idle_ready_valid", 32'(bus.valid), 32'd0);
      check("idle_ready_q", 32'(bus.q), 32'hd);

      // Gapped strobe.
      send_frame(4'b1101, 2, 3, 1'b0, 1'b0, 1'b1);
      sb_compare("gap");
      check("gap_valid", 32'(bus.valid), 32'd1);
      bus.ready = 1'b1;
      tick();
      bus.ready = 1'b0;

      // Overrun: second word is dropped, ovf sticks.
      send_frame(4'b1101, -1, 0, 1'b0, 1'b0, 1'b1);
      sb_compare("ovr_first");
      check("ovr_first_ovf", 32'(bus.ovf), 32'd0);
      send_frame(4'b0010, -1, 0, 1'b0, 1'b0, 1'b0);
      check("ovr_q", 32'(bus.q), 32'hd);
      check("ovr_valid", 32'(bus.valid), 32'd1);
      check("ovr_ovf", 32'(bus.ovf), 32'd1);
      bus.ready = 1'b1;
      tick();
      bus.ready = 1'b0;
      tick();
      check("ovr_sticky", 32'(bus.ovf), 32'd1);
      do_reset();
      check("ovr_cleared", 32'(bus.ovf), 32'd0);

      // Handshake on the completion edge loads the new word and keeps valid.
      send_frame(4'b1101, -1, 0, 1'b0, 1'b0, 1'b1);
      sb_compare("same_first");
      send_frame(4'b0110, -1, 0, 1'b0, 1'b1, 1'b1);
      sb_compare("same");
      check("same_valid", 32'(bus.valid), 32'd1);
      check("same_ovf", 32'(bus.ovf), 32'd0);
      bus.ready = 1'b1;
      tick();
      bus.ready = 1'b0;

      // Mid-frame reset.
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.en = 1'b1;
         bus.SI = 1'b1;
         tick();
      end
      bus.en = 1'b0;
      do_reset();
      check("mid_busy", 32'(bus.busy), 32'd0);
      check("mid_q", 32'(bus.q), 32'd0);
      check("mid_valid", 32'(bus.valid), 32'd0);
      check("mid_ovf", 32'(bus.ovf), 32'd0);
      send_frame(4'b1001, -1, 0, 1'b0, 1'b0, 1'b1);
      sb_compare("mid_after");
      check("mid_after_valid", 32'(bus.valid), 32'd1);
      bus.ready = 1'b1;
      tick();
      bus.ready = 1'b0;

      // en in IDLE captures nothing; start inside a frame does not restart it.
      for (int i = 0; i < 3; i++) begin
         bus.en = 1'b1;
         bus.SI = 1'b1;
         tick();
      end
      bus.en = 1'b0;
      check("idle_en_busy", 32'(bus.busy), 32'd0);
      check("idle_en_valid", 32'(bus.valid), 32'd0);
      check("idle_en_q", 32'(bus.q), 32'h9);
      send_frame(4'b0110, -1, 0, 1'b1, 1'b0, 1'b1);
      sb_compare("ign_start");
      check("ign_start_busy", 32'(bus.busy), 32'd0);
      check("ign_start_valid", 32'(bus.valid), 32'd1);

      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/ser2par_rx.md
SER2PAR_RX -- requirements
Module: ser2par_rx

Interface
REQ-001 Parameter: N, default 4, word width in bits and number of bits per frame; N >= 2.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-low (rst=0 resets on the next rising clk edge).
REQ-004 Port: en  input  1  bit strobe; SI is sampled only on edges where en=1.
REQ-005 Port: SI  input  1  serial data in, LSB-first; driven by the upstream right-shift register's SO.
REQ-006 Port: start  input  1  frame-start pulse; one cycle wide.
REQ-007 Port: ready  input  1  downstream accepts the held word when valid=1 and ready=1.
REQ-008 Port: q  output  N  assembled parallel word (output register).
REQ-009 Port: valid  output  1  q holds an unconsumed word.
REQ-010 Port: busy  output  1  frame in progress (state SHIFT).
REQ-011 Port: ovf  output  1  sticky overrun flag.

Function
REQ-012 FSM states: IDLE, SHIFT; encoding is free.
REQ-013 IDLE: start=1 -> SHIFT, bit counter cleared to 0, shift register cleared to 0; SI is not sampled on that edge, even if en=1.
REQ-014 IDLE, start=0: hold all state; en and SI are ignored.
REQ-015 SHIFT, en=1: shift register <= {SI, sr[N-1:1]}; counter increments by 1.
REQ-016 SHIFT, en=0: shift register and counter hold.
REQ-017 SHIFT: start is ignored; a new frame is not restarted.
REQ-018 Completion edge: SHIFT with en=1 and counter = N-1.
- next state is IDLE;
- the completed word is {SI, sr[N-1:1]}.
REQ-019 Completion, output free (valid=0, or valid=1 and ready=1): q <= completed word; valid=1 after the edge.
REQ-020 Completion, output occupied (valid=1 and ready=0): completed word is discarded; q and valid hold; ovf <= 1.
REQ-021 Latency: q and valid update on the same edge that samples the Nth bit; both are visible in the following cycle.
REQ-022 Handshake, no completion: valid=1 and ready=1 -> valid <= 0; q holds its last value.
REQ-023 Handshake: ready while valid=0 has no effect.
REQ-024 Handshake and completion on the same edge: the new word loads and valid stays 1.
REQ-025 ovf is sticky; it is cleared only by reset.
REQ-026 busy = 1 exactly when the state is SHIFT (registered-state decode).
REQ-027 Counter width: clog2(N) bits; it never exceeds N-1.
REQ-028 Bit order: the first received bit lands in q[0] and the Nth in q[N-1]; a right-shifting source's word is thus reproduced unchanged.

Reset
REQ-029 rst=0 at a rising edge, in any state including mid-frame: state <= IDLE; counter <= 0; shift register <= 0; q <= 0; valid <= 0; ovf <= 0.
REQ-030 Reset overrides start, en and ready on the same edge.
REQ-031 After reset, busy=0; any partial frame is lost with no ovf.

Verification (N=4)
REQ-032 Basic frame: start pulse, then en=1 with SI = 1,0,1,1 on 4 consecutive edges -> next cycle q=4'b1101, valid=1, busy=0, ovf=0.
REQ-033 Gapped strobe: same frame with en=0 for 3 cycles between bits 2 and 3 -> q=4'b1101; valid rises exactly one cycle after the 4th en edge.
REQ-034 Overrun: ready=0, frame 4'b1101 then frame 4'b0010 -> q stays 4'b1101, valid=1, ovf=1.
REQ-035 Same-edge handshake: valid=1 with q=4'b1101, ready=1 on the completion edge of frame 4'b0110 -> q=4'b0110, valid=1, ovf=0.
REQ-036 Mid-frame reset: rst=0 after 2 bits -> next cycle busy=0, q=0, valid=0, ovf=0; a following full frame 4'b1001 is received correctly.
REQ-037 Ignored start: start=1 pulses during SHIFT and en=1 pulses during IDLE -> no restart and no capture; the frame result is unchanged.
